// File: rtl/adder_seq_pkg.sv
// Shared constants, FSM state type and sizing helper for the sequential slice adder.
package adder_seq_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/adder_slice3.sv
// 3-bit ripple-carry slice; port list matches the partition netlist so an approximated version drops in.
// Purely combinational, no latency, no flow control.
module adder_slice3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] sum,
  output logic       cout
);

  logic [3:0] c;

  always_comb begin
    c      = '0;
    sum    = '0;
    c[0]   = cin;
    for (int i = 0; i < 3; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[3];
  end

endmodule

// File: rtl/adder_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 3-bit slice per cycle, LSB first. Result valid NSLICE edges after accept.
// Result held stable in DONE until out_ready; new requests only accepted in IDLE (no buffering).
// Optional ADDER_SEQ_EXACT_CHECK_EN adds exact_err comparing the result against a registered exact sum.
module adder_slice_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef ADDER_SEQ_EXACT_CHECK_EN
  output logic             exact_err,
`endif
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("adder_slice_sequencer: WIDTH must be a positive multiple of 3");
  end

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-1:0]     res_sh;
  logic                 carry;
  logic [CNT_W-1:0]     cnt;
  logic [SLICE_W-1:0]   slice_sum;
  logic                 slice_cout;
  logic                 last_step;

  assign last_step = (cnt == CNT_W'(NSLICE - 1));

  adder_slice3 u_slice (
    .a    (a_sh[SLICE_W-1:0]),
    .b    (b_sh[SLICE_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands drain LSB-first while sum digits enter at the top, so res_sh is aligned after NSLICE steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          res_sh <= (res_sh >> SLICE_W) | (WIDTH'(slice_sum) << (WIDTH - SLICE_W));
          a_sh   <= a_sh >> SLICE_W;
          b_sh   <= b_sh >> SLICE_W;
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = res_sh;
  assign out_cout  = carry;

`ifdef ADDER_SEQ_EXACT_CHECK_EN
  logic [WIDTH:0] exact_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_sum <= '0;
    end else if ((state == IDLE) && in_valid) begin
      exact_sum <= {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
    end
  end

  assign exact_err = (state == DONE) && ({carry, res_sh} != exact_sum);
`endif

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Bench for adder_slice_sequencer: cycle-level behavioural model plus directed literal vectors.
module tb_adder_slice_sequencer;

  localparam int WIDTH  = 12;
  localparam int NSLICE = WIDTH / 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef ADDER_SEQ_EXACT_CHECK_EN
  logic             exact_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  adder_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef ADDER_SEQ_EXACT_CHECK_EN
    .exact_err (exact_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: an op is in flight from its accept edge; result is due NSLICE edges later and leaves on out_ready.
  logic             m_inflight = 1'b0;
  int               m_edges    = 0;
  logic [WIDTH:0]   m_q[$];
  bit               m_acc, m_dlv;
  logic [WIDTH:0]   m_new;

  initial begin
    forever begin
      @(negedge clk);
      m_acc = 1'b0;
      m_dlv = 1'b0;
      if (!rst_n) begin
        m_inflight = 1'b0;
        m_edges    = 0;
        m_q.delete();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(!m_inflight));
        chk("out_valid", 32'(out_valid), 32'(m_inflight && m_edges >= NSLICE));
        chk("busy", 32'(busy), 32'(m_inflight));
        if (m_inflight && m_edges >= NSLICE && m_q.size() > 0)
          chk("result", 32'({out_cout, out_sum}), 32'(m_q[0]));
`ifdef ADDER_SEQ_EXACT_CHECK_EN
        chk("exact_err", 32'(exact_err), 32'd0);
`endif
        m_acc = in_valid && !m_inflight;
        m_dlv = m_inflight && (m_edges >= NSLICE) && out_ready;
        m_new = {1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(in_cin);
      end
      @(posedge clk);
      if (rst_n) begin
        if (m_acc) begin
          m_q.push_back(m_new);
          m_inflight = 1'b1;
          m_edges    = 0;
        end else if (m_dlv) begin
          void'(m_q.pop_front());
          m_inflight = 1'b0;
        end else if (m_inflight && m_edges < NSLICE) begin
          m_edges++;
        end
      end
    end
  end

  // One operation; pre=1 means the request is already being driven by the caller.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                       input logic [WIDTH-1:0] es, input logic ec, input int hold,
                       input bit lit, input bit poke, input bit pre);
    int n;
    if (!pre) begin
      @(posedge clk); #1;
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    if (lit) begin
      // first negedge after the accept edge counts as 1, so valid shows at NSLICE+1
      chk("latency", 32'(n), 32'd5);
      chk("lit_sum", 32'(out_sum), 32'(es));
      chk("lit_cout", 32'(out_cout), 32'(ec));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (poke) begin
        in_valid = 1'($urandom);
        in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
      end
    end
    if (lit && hold > 0) begin
      @(negedge clk);
      chk("held_valid", 32'(out_valid), 32'd1);
      chk("held_sum", 32'(out_sum), 32'(es));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    if (lit) chk("idle_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    in_valid = 1'b1; in_a = 12'hFFF; in_b = 12'h001; in_cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lit_ready", 32'(in_ready), 32'd1);
    chk("rst_lit_sum", 32'(out_sum), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    // full carry chain, accepted on the first edge after release
    do_op(12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 0, 1, 0, 1);
    do_op(12'h000, 12'h000, 1'b1, 12'h001, 1'b0, 0, 1, 0, 0);
    do_op(12'h924, 12'h492, 1'b1, 12'hDB7, 1'b0, 0, 1, 0, 0);
    do_op(12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 1, 1, 0, 0);
    do_op(12'hABC, 12'h123, 1'b1, 12'hBE0, 1'b0, 2, 1, 0, 0);
    // backpressure with ignored request pulses
    do_op(12'h555, 12'hAAA, 1'b1, 12'h000, 1'b1, 5, 1, 1, 0);

    // reset two slices into RUN
    @(posedge clk); #1;
    in_a = 12'hFFF; in_b = 12'h001; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    do_op(12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 0, 1, 0, 0);

    for (int k = 0; k < 300; k++)
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), '0, 1'b0,
            int'($urandom_range(0, 2)), 0, 1, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
